// File: rtl/spi_slv.sv
// SPI mode-0 responder: oversamples SCLK/MOSI/SS_N on clk, shifts a preloaded word
// out on MISO and collects MOSI into a right-aligned receive word.
module spi_slv #(
    parameter int CLK_DIVIDE = 100,
    parameter int SPI_MAXLEN = 32
) (
    input  logic                          clk,
    input  logic                          aresetn,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    input  logic [$clog2(SPI_MAXLEN):0]   tx_len,
    input  logic [SPI_MAXLEN-1:0]         tx_data,
    output logic                          rx_valid,
    output logic [SPI_MAXLEN-1:0]         rx_data,
    output logic [$clog2(SPI_MAXLEN):0]   rx_len,
    output logic                          rx_overflow,
    output logic                          tx_underrun,
    output logic                          busy,
    input  logic                          SCLK,
    input  logic                          MOSI,
    input  logic                          SS_N,
    output logic                          MISO,
    output logic                          MISO_oe
);

    localparam int IW = $clog2(SPI_MAXLEN);
    localparam int LW = IW + 1;
    localparam logic [LW-1:0] MAXLEN = LW'(SPI_MAXLEN);

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    state_t state, state_nxt;

    logic sclk_s1, sclk_s2, sclk_d;
    logic mosi_s1, mosi_s2;
    logic ss_s1, ss_s2, ss_d;
    logic [1:0] fill;
    logic armed;
    logic sclk_rise, sclk_fall, ss_fall, ss_rise;

    logic                  hold_full;
    logic [SPI_MAXLEN-1:0] hold_data;
    logic [LW-1:0]         hold_len;
    logic [LW-1:0]         tx_len_c;

    logic [SPI_MAXLEN-1:0] tx_shift;
    logic [SPI_MAXLEN-1:0] rx_shift;
    logic [LW-1:0]         idx;
    logic [LW-1:0]         bit_cnt;
    logic                  ovf_flag;
    logic                  udr_flag;
    logic [IW-1:0]         first_sel;
    logic [IW-1:0]         next_sel;

    if (CLK_DIVIDE < 8 || (CLK_DIVIDE % 2) != 0) begin : g_bad_clk_divide
        $error("CLK_DIVIDE must be even and at least 8");
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_d  <= 1'b0;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
            ss_s1   <= 1'b1;
            ss_s2   <= 1'b1;
            ss_d    <= 1'b1;
            fill    <= 2'd0;
            armed   <= 1'b0;
        end else begin
            sclk_s1 <= SCLK;
            sclk_s2 <= sclk_s1;
            sclk_d  <= sclk_s2;
            mosi_s1 <= MOSI;
            mosi_s2 <= mosi_s1;
            ss_s1   <= SS_N;
            ss_s2   <= ss_s1;
            ss_d    <= ss_s2;
            if (fill != 2'd2) fill <= fill + 2'd1;
            // SS_N must be seen high through a refilled chain before a fall counts
            if (fill == 2'd2 && ss_s2) armed <= 1'b1;
        end
    end

    assign sclk_rise = sclk_s2 & ~sclk_d;
    assign sclk_fall = ~sclk_s2 & sclk_d;
    assign ss_fall   = armed & ss_d & ~ss_s2;
    assign ss_rise   = ~ss_d & ss_s2;

    assign tx_ready  = ~hold_full;
    assign tx_len_c  = (tx_len > MAXLEN) ? MAXLEN : tx_len;
    assign first_sel = hold_len[IW-1:0] - IW'(1);
    assign next_sel  = idx[IW-1:0] - IW'(2);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            hold_full <= 1'b0;
            hold_data <= '0;
            hold_len  <= '0;
        end else if (state == IDLE && ss_fall && hold_full) begin
            hold_full <= 1'b0;
        end else if (tx_valid && !hold_full) begin
            hold_full <= 1'b1;
            hold_data <= tx_data;
            hold_len  <= tx_len_c;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ss_fall) state_nxt = ACTIVE;
            ACTIVE:  if (ss_rise) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state == ACTIVE);
        MISO_oe  = (state == ACTIVE);
        rx_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            tx_shift    <= '0;
            rx_shift    <= '0;
            idx         <= '0;
            bit_cnt     <= '0;
            ovf_flag    <= 1'b0;
            udr_flag    <= 1'b0;
            MISO        <= 1'b0;
            rx_data     <= '0;
            rx_len      <= '0;
            rx_overflow <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    MISO <= 1'b0;
                    if (ss_fall) begin
                        bit_cnt  <= '0;
                        rx_shift <= '0;
                        ovf_flag <= 1'b0;
                        if (hold_full) begin
                            tx_shift <= hold_data;
                            idx      <= hold_len;
                            MISO     <= (hold_len != '0) ? hold_data[first_sel] : 1'b0;
                            udr_flag <= 1'b0;
                        end else begin
                            tx_shift <= '0;
                            idx      <= '0;
                            udr_flag <= 1'b1;
                        end
                    end
                end
                ACTIVE: begin
                    if (ss_rise) begin
                        // SS_N release wins over any coincident SCLK edge
                        MISO        <= 1'b0;
                        rx_data     <= rx_shift;
                        rx_len      <= bit_cnt;
                        rx_overflow <= ovf_flag;
                        tx_underrun <= udr_flag;
                    end else if (sclk_rise) begin
                        if (bit_cnt < MAXLEN) begin
                            rx_shift <= {rx_shift[SPI_MAXLEN-2:0], mosi_s2};
                            bit_cnt  <= bit_cnt + LW'(1);
                        end else begin
                            ovf_flag <= 1'b1;
                        end
                    end else if (sclk_fall) begin
                        if (idx > LW'(1)) begin
                            idx  <= idx - LW'(1);
                            MISO <= tx_shift[next_sel];
                        end else begin
                            idx  <= '0;
                            MISO <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    ovf_flag <= 1'b0;
                    udr_flag <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    tx_len_legal: assert property (@(posedge clk) disable iff (!aresetn)
        (tx_valid && tx_ready) |-> (tx_len <= MAXLEN));

endmodule
